// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one req/gnt/rvalid memory port between the instruction-fetch
//   requester (port I) and the load/store requester (port D). Responses come
//   back in order. A small owner-ID FIFO routes each response to the port that
//   issued the request. A fetch flush marks in-flight I responses for discard.
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   i_req_i/i_addr_i/i_gnt_o       fetch request channel
//   i_rvalid_o/i_rdata_o/i_err_o   fetch response channel
//   i_flush_i                      drop every fetch response outstanding now
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i/d_gnt_o   data request channel
//   d_rvalid_o/d_rdata_o/d_err_o   data response channel
//   mem_*                          shared memory port (request + response)
//   busy_o                         at least one transaction outstanding
//   proto_err_o                    sticky: response seen with nothing outstanding
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          D_PRIORITY      = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        i_flush_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  // Outstanding-transaction FIFO
  owner_e                     owner_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] valid_q;
  logic [MAX_OUTSTANDING-1:0] discard_q;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;

  // Arbitration state
  logic   lock_valid;
  owner_e lock_owner;
  owner_e last_owner;
  logic   proto_err_q;

  owner_e sel;
  logic   sel_req;
  logic   full;
  logic   sel_gnt;
  logic   pop;
  owner_e head_owner;
  logic   head_discard;
  logic   fwd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel     = OWN_D;
    sel_req = 1'b0;
    if (lock_valid) begin
      // A stalled request must stay on the bus unchanged until it is granted.
      sel     = lock_owner;
      sel_req = (lock_owner == OWN_D) ? d_req_i : i_req_i;
    end else if (d_req_i && i_req_i) begin
      sel     = (D_PRIORITY || last_owner == OWN_I) ? OWN_D : OWN_I;
      sel_req = 1'b1;
    end else if (d_req_i) begin
      sel     = OWN_D;
      sel_req = 1'b1;
    end else if (i_req_i) begin
      sel     = OWN_I;
      sel_req = 1'b1;
    end
  end

  // A pop in the same cycle does not free a slot for this cycle's request.
  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign mem_req_o = sel_req & ~full;
  assign sel_gnt   = mem_req_o & mem_gnt_i;
  assign i_gnt_o   = sel_gnt & (sel == OWN_I);
  assign d_gnt_o   = sel_gnt & (sel == OWN_D);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_req) begin
      if (sel == OWN_D) begin
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = i_addr_i;
      end
    end
  end

  // Response routing. A flush in the pop cycle also kills an I head entry.
  assign pop          = mem_rvalid_i & (count != '0);
  assign head_owner   = owner_q[rd_ptr];
  assign head_discard = discard_q[rd_ptr] | (i_flush_i & (head_owner == OWN_I));
  assign fwd          = pop & ~head_discard;

  assign i_rvalid_o = fwd & (head_owner == OWN_I);
  assign d_rvalid_o = fwd & (head_owner == OWN_D);
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  assign i_err_o    = i_rvalid_o & mem_err_i;
  assign d_err_o    = d_rvalid_o & mem_err_i;

  assign busy_o      = (count != '0);
  assign proto_err_o = proto_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the FIFO entries are reset too, so a response to a transaction
      // issued before reset can never be routed from stale owner/discard bits.
      for (int i = 0; i < MAX_OUTSTANDING; i++) owner_q[i] <= OWN_I;
      valid_q     <= '0;
      discard_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      lock_valid  <= 1'b0;
      lock_owner  <= OWN_I;
      last_owner  <= OWN_D;
      proto_err_q <= 1'b0;
    end else begin
      if (i_flush_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (valid_q[i] && owner_q[i] == OWN_I) discard_q[i] <= 1'b1;
        end
      end

      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end

      // The slot at wr_ptr is never valid here, so a grant in the flush cycle
      // lands with discard clear (the later assignment wins).
      if (sel_gnt) begin
        owner_q[wr_ptr]   <= sel;
        valid_q[wr_ptr]   <= 1'b1;
        discard_q[wr_ptr] <= 1'b0;
        wr_ptr            <= ptr_inc(wr_ptr);
        last_owner        <= sel;
      end

      case ({sel_gnt, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (sel_gnt) begin
        lock_valid <= 1'b0;
      end else if (mem_req_o) begin
        lock_valid <= 1'b1;
        lock_owner <= sel;
      end

      if (mem_rvalid_i && count == '0) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances share all inputs:
// dut_p uses fixed D priority, dut_r uses round-robin. Directed scenarios
// use hand-derived constants. A random scenario compares against a
// queue-based model of the arbitration and response-routing rules.
module tb_mem_port_arbiter;

  localparam int unsigned MAXO = 2;

  typedef struct packed {
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        proto_err;
  } obs_t;

  typedef struct {
    bit own_d;
    bit disc;
  } ent_t;

  logic        clk, rstn;
  logic        i_req, i_flush, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  logic        p_i_gnt, p_i_rvalid, p_i_err, p_d_gnt, p_d_rvalid, p_d_err;
  logic        p_mem_req, p_mem_we, p_busy, p_proto;
  logic [31:0] p_i_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_be;
  logic        r_i_gnt, r_i_rvalid, r_i_err, r_d_gnt, r_d_rvalid, r_d_err;
  logic        r_mem_req, r_mem_we, r_busy, r_proto;
  logic [31:0] r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  obs_t p_o, r_o, o;
  bit   use_rr;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .D_PRIORITY(1'b1)) dut_p (
    .clk(clk), .rstn(rstn),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(p_i_gnt), .i_rvalid_o(p_i_rvalid),
    .i_rdata_o(p_i_rdata), .i_err_o(p_i_err), .i_flush_i(i_flush),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(p_d_gnt), .d_rvalid_o(p_d_rvalid), .d_rdata_o(p_d_rdata), .d_err_o(p_d_err),
    .mem_req_o(p_mem_req), .mem_we_o(p_mem_we), .mem_be_o(p_mem_be), .mem_addr_o(p_mem_addr),
    .mem_wdata_o(p_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(p_busy), .proto_err_o(p_proto)
  );

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .D_PRIORITY(1'b0)) dut_r (
    .clk(clk), .rstn(rstn),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(r_i_gnt), .i_rvalid_o(r_i_rvalid),
    .i_rdata_o(r_i_rdata), .i_err_o(r_i_err), .i_flush_i(i_flush),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(r_d_gnt), .d_rvalid_o(r_d_rvalid), .d_rdata_o(r_d_rdata), .d_err_o(r_d_err),
    .mem_req_o(r_mem_req), .mem_we_o(r_mem_we), .mem_be_o(r_mem_be), .mem_addr_o(r_mem_addr),
    .mem_wdata_o(r_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(r_busy), .proto_err_o(r_proto)
  );

  assign p_o = {p_i_gnt, p_i_rvalid, p_i_rdata, p_i_err, p_d_gnt, p_d_rvalid, p_d_rdata,
                p_d_err, p_mem_req, p_mem_we, p_mem_be, p_mem_addr, p_mem_wdata, p_busy, p_proto};
  assign r_o = {r_i_gnt, r_i_rvalid, r_i_rdata, r_i_err, r_d_gnt, r_d_rvalid, r_d_rdata,
                r_d_err, r_mem_req, r_mem_we, r_mem_be, r_mem_addr, r_mem_wdata, r_busy, r_proto};
  assign o   = use_rr ? r_o : p_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rstn = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_reset();
    use_rr = 0;
    apply_reset();
    #1;
    checks++; if (p_o !== '0) begin errors++; $display("FAIL reset_p got %h exp 0", p_o); end
    checks++; if (r_o !== '0) begin errors++; $display("FAIL reset_r got %h exp 0", r_o); end
    step(); #1;
    checks++; if ({o.busy, o.proto_err, o.mem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got %b exp 000", {o.busy, o.proto_err, o.mem_req}); end
  endtask

  task automatic test_single_fetch();
    use_rr = 0;
    apply_reset();
    i_req = 1; i_addr = 32'h100; mem_gnt = 1; #1;
    checks++; if ({o.i_gnt, o.d_gnt, o.mem_req, o.mem_we} !== 4'b1010) begin
      errors++; $display("FAIL fetch_gnt got %b exp 1010", {o.i_gnt, o.d_gnt, o.mem_req, o.mem_we}); end
    checks++; if ({o.mem_addr, o.mem_be, o.mem_wdata} !== {32'h100, 4'hF, 32'h0}) begin
      errors++; $display("FAIL fetch_payload got %h/%h/%h", o.mem_addr, o.mem_be, o.mem_wdata); end
    checks++; if (o.busy !== 1'b0) begin errors++; $display("FAIL fetch_busy0 got %b exp 0", o.busy); end
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'h13; #1;
    checks++; if ({o.i_rvalid, o.d_rvalid, o.busy} !== 3'b101) begin
      errors++; $display("FAIL fetch_rvalid got %b exp 101", {o.i_rvalid, o.d_rvalid, o.busy}); end
    checks++; if ({o.i_rdata, o.d_rdata} !== {32'h13, 32'h0}) begin
      errors++; $display("FAIL fetch_rdata got %h %h exp 13 0", o.i_rdata, o.d_rdata); end
    step();
    idle(); #1;
    checks++; if ({o.busy, o.i_rvalid} !== 2'b00) begin
      errors++; $display("FAIL fetch_busy_end got %b exp 00", {o.busy, o.i_rvalid}); end
  endtask

  // D wins twice under fixed priority; responses return D, D, I.
  task automatic test_contention();
    logic [1:0] exp_gnt [3] = '{2'b01, 2'b01, 2'b10};
    logic [1:0] exp_rv  [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [31:0] dat    [4] = '{32'h0, 32'hA, 32'hB, 32'hC};
    use_rr = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      i_req = (c < 3); i_addr = 32'h200; d_req = (c < 2); d_addr = 32'h800 + c;
      d_be = 4'h3; mem_gnt = (c < 3); mem_rvalid = (c > 0); mem_rdata = dat[c]; #1;
      if (c < 3) begin
        checks++; if ({o.i_gnt, o.d_gnt} !== exp_gnt[c]) begin
          errors++; $display("FAIL contend_gnt c%0d got %b exp %b", c, {o.i_gnt, o.d_gnt}, exp_gnt[c]); end
      end
      checks++; if ({o.i_rvalid, o.d_rvalid} !== exp_rv[c]) begin
        errors++; $display("FAIL contend_route c%0d got %b exp %b", c, {o.i_rvalid, o.d_rvalid}, exp_rv[c]); end
      step();
    end
    idle();
  endtask

  // Round-robin instance: grants alternate I, D, I, D from reset.
  task automatic test_round_robin();
    use_rr = 1;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      i_req = (c < 4); d_req = (c < 4); i_addr = 32'h40; d_addr = 32'h80;
      mem_gnt = (c < 4); mem_rvalid = (c > 0); mem_rdata = 32'h1000 + c; #1;
      if (c < 4) begin
        checks++; if ({o.i_gnt, o.d_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_gnt c%0d got %b", c, {o.i_gnt, o.d_gnt}); end
      end
      if (c > 0) begin
        checks++; if ({o.i_rvalid, o.d_rvalid} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_route c%0d got %b", c, {o.i_rvalid, o.d_rvalid}); end
      end
      step();
    end
    idle();
  endtask

  // I stalls three cycles; D arrives meanwhile and must wait for I's grant.
  task automatic test_lock();
    use_rr = 0;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      i_req = (c < 4); i_addr = 32'h200; d_req = (c >= 1); d_addr = 32'h300; d_we = 1;
      d_be = 4'hC; d_wdata = 32'hCAFE; mem_gnt = (c >= 3); #1;
      if (c < 4) begin
        checks++; if ({o.mem_req, o.mem_addr, o.d_gnt, o.i_gnt} !== {1'b1, 32'h200, 1'b0, (c == 3)}) begin
          errors++; $display("FAIL lock_hold c%0d got req %b addr %h dg %b ig %b", c, o.mem_req, o.mem_addr, o.d_gnt, o.i_gnt); end
      end else begin
        checks++; if ({o.d_gnt, o.mem_addr, o.mem_we, o.mem_be, o.mem_wdata} !== {1'b1, 32'h300, 1'b1, 4'hC, 32'hCAFE}) begin
          errors++; $display("FAIL lock_release got dg %b addr %h we %b be %h wd %h", o.d_gnt, o.mem_addr, o.mem_we, o.mem_be, o.mem_wdata); end
      end
      step();
    end
    idle();
  endtask

  // Two grants fill the FIFO; a pop in cycle 3 allows a grant in cycle 4.
  task automatic test_full();
    logic [1:0] exp_rg [5] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    use_rr = 0;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      i_req = 1; i_addr = 32'h500 + 4 * c; mem_gnt = 1; mem_rvalid = (c == 3); #1;
      checks++; if ({o.mem_req, o.i_gnt} !== exp_rg[c]) begin
        errors++; $display("FAIL full_c%0d got %b exp %b", c, {o.mem_req, o.i_gnt}, exp_rg[c]); end
      if (c == 3) begin
        checks++; if (o.i_rvalid !== 1'b1) begin errors++; $display("FAIL full_pop got %b exp 1", o.i_rvalid); end
      end
      step();
    end
    idle(); mem_rvalid = 1; step(); step(); idle(); #1;
    checks++; if (o.busy !== 1'b0) begin errors++; $display("FAIL full_drain got %b exp 0", o.busy); end
  endtask

  task automatic test_flush();
    use_rr = 0;
    apply_reset();
    i_req = 1; i_addr = 32'h10; mem_gnt = 1; step();
    i_addr = 32'h14; step();
    idle(); i_flush = 1; #1;
    checks++; if ({o.busy, o.i_rvalid} !== 2'b10) begin errors++; $display("FAIL flush_busy got %b exp 10", {o.busy, o.i_rvalid}); end
    step();
    for (int c = 0; c < 2; c++) begin
      idle(); mem_rvalid = 1; mem_rdata = 32'hBAD0 + c; #1;
      checks++; if ({o.i_rvalid, o.d_rvalid, o.busy} !== 3'b001) begin
        errors++; $display("FAIL flush_drop%0d got %b exp 001", c, {o.i_rvalid, o.d_rvalid, o.busy}); end
      step();
    end
    idle(); i_req = 1; i_addr = 32'h2000; mem_gnt = 1; #1;
    checks++; if ({o.busy, o.i_gnt} !== 2'b01) begin errors++; $display("FAIL flush_refetch got %b exp 01", {o.busy, o.i_gnt}); end
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'h55; #1;
    checks++; if ({o.i_rvalid, o.i_rdata} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL flush_after got %b %h exp 1 55", o.i_rvalid, o.i_rdata); end
    step();
    idle(); mem_rvalid = 1; #1;
    checks++; if ({o.busy, o.proto_err, o.i_rvalid} !== 3'b000) begin
      errors++; $display("FAIL stray_pre got %b exp 000", {o.busy, o.proto_err, o.i_rvalid}); end
    step();
    idle(); #1;
    checks++; if (o.proto_err !== 1'b1) begin errors++; $display("FAIL stray_proto got %b exp 1", o.proto_err); end
    step(); #1;
    checks++; if (o.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", o.proto_err); end
  endtask

  // Flush coinciding with an I pop and a new I grant; D unaffected by flush.
  task automatic test_flush_same_cycle();
    use_rr = 0;
    apply_reset();
    i_req = 1; i_addr = 32'h300; mem_gnt = 1; step();
    i_addr = 32'h400; i_flush = 1; mem_rvalid = 1; mem_rdata = 32'h66; #1;
    checks++; if ({o.i_rvalid, o.i_gnt, o.i_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL flush_pop got rv %b gnt %b data %h", o.i_rvalid, o.i_gnt, o.i_rdata); end
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'h77; mem_err = 1; #1;
    checks++; if ({o.i_rvalid, o.i_rdata, o.i_err} !== {1'b1, 32'h77, 1'b1}) begin
      errors++; $display("FAIL flush_newpc got rv %b data %h err %b", o.i_rvalid, o.i_rdata, o.i_err); end
    step();
    idle(); d_req = 1; d_addr = 32'h900; mem_gnt = 1; step();
    idle(); i_flush = 1; mem_rvalid = 1; mem_rdata = 32'h88; #1;
    checks++; if ({o.d_rvalid, o.d_rdata, o.i_rvalid} !== {1'b1, 32'h88, 1'b0}) begin
      errors++; $display("FAIL flush_d got rv %b data %h irv %b", o.d_rvalid, o.d_rdata, o.i_rvalid); end
    step();
    idle();
  endtask

  // Reset with a transaction in flight: its late response is not forwarded.
  task automatic test_reset_mid();
    use_rr = 0;
    apply_reset();
    i_req = 1; i_addr = 32'h600; mem_gnt = 1; step();
    idle(); rstn = 0; step();
    rstn = 1; mem_rvalid = 1; mem_rdata = 32'h99; #1;
    checks++; if ({o.i_rvalid, o.d_rvalid, o.busy, o.proto_err} !== 4'b0000) begin
      errors++; $display("FAIL midreset_resp got %b exp 0000", {o.i_rvalid, o.d_rvalid, o.busy, o.proto_err}); end
    step();
    idle(); #1;
    checks++; if (o.proto_err !== 1'b1) begin errors++; $display("FAIL midreset_proto got %b exp 1", o.proto_err); end
  endtask

  // Random traffic against a queue model of the arbitration/routing rules.
  task automatic test_random(input bit rr, input int ncyc);
    ent_t q[$];
    ent_t ent, h;
    bit   lock_v, lock_d, last_d, proto, i_pend, d_pend;
    bit   sel_v, sel_d, e_req, e_gnt, pop, e_irv, e_drv;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    bit   e_we;
    use_rr = rr;
    apply_reset();
    lock_v = 0; lock_d = 0; last_d = 1; proto = 0; i_pend = 0; d_pend = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_addr = $urandom; d_we = $urandom_range(0, 1); d_be = 4'($urandom); d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend;
      i_flush = ($urandom_range(0, 9) == 0);
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom; mem_err = ($urandom_range(0, 7) == 0);

      if (lock_v) begin sel_d = lock_d; sel_v = lock_d ? d_req : i_req; end
      else if (i_req && d_req) begin sel_v = 1; sel_d = rr ? !last_d : 1'b1; end
      else begin sel_v = i_req | d_req; sel_d = d_req; end
      e_req = sel_v && (q.size() < MAXO);
      e_gnt = e_req && mem_gnt;
      pop = mem_rvalid && (q.size() > 0);
      e_irv = 0; e_drv = 0;
      if (pop) begin
        h = q[0];
        if (!(h.disc || (i_flush && !h.own_d))) begin e_irv = !h.own_d; e_drv = h.own_d; end
      end
      e_addr = sel_d ? d_addr : i_addr; e_be = sel_d ? d_be : 4'hF;
      e_we = sel_d && d_we; e_wdata = sel_d ? d_wdata : 32'h0;
      #1;
      checks++; if ({o.mem_req, o.i_gnt, o.d_gnt} !== {e_req, e_gnt && !sel_d, e_gnt && sel_d}) begin
        errors++; $display("FAIL rnd_gnt rr%0d c%0d got %b exp %b", rr, c, {o.mem_req, o.i_gnt, o.d_gnt}, {e_req, e_gnt && !sel_d, e_gnt && sel_d}); end
      checks++; if ({o.i_rvalid, o.d_rvalid, o.i_err, o.d_err} !== {e_irv, e_drv, e_irv && mem_err, e_drv && mem_err}) begin
        errors++; $display("FAIL rnd_route rr%0d c%0d got %b exp %b", rr, c, {o.i_rvalid, o.d_rvalid, o.i_err, o.d_err}, {e_irv, e_drv, e_irv && mem_err, e_drv && mem_err}); end
      checks++; if ({o.i_rdata, o.d_rdata} !== {e_irv ? mem_rdata : 32'h0, e_drv ? mem_rdata : 32'h0}) begin
        errors++; $display("FAIL rnd_rdata rr%0d c%0d got %h %h", rr, c, o.i_rdata, o.d_rdata); end
      checks++; if ({o.busy, o.proto_err} !== {q.size() != 0, proto}) begin
        errors++; $display("FAIL rnd_status rr%0d c%0d got %b exp %b", rr, c, {o.busy, o.proto_err}, {q.size() != 0, proto}); end
      if (e_req) begin
        checks++; if ({o.mem_addr, o.mem_be, o.mem_we, o.mem_wdata} !== {e_addr, e_be, e_we, e_wdata}) begin
          errors++; $display("FAIL rnd_payload rr%0d c%0d got %h %h %b %h exp %h %h %b %h", rr, c, o.mem_addr, o.mem_be, o.mem_we, o.mem_wdata, e_addr, e_be, e_we, e_wdata); end
      end
      @(posedge clk);
      if (mem_rvalid && q.size() == 0) proto = 1;
      if (i_flush) foreach (q[k]) begin ent = q[k]; if (!ent.own_d) ent.disc = 1; q[k] = ent; end
      if (pop) void'(q.pop_front());
      if (e_gnt) begin
        ent.own_d = sel_d; ent.disc = 0; q.push_back(ent); last_d = sel_d;
        if (sel_d) d_pend = 0; else i_pend = 0;
        lock_v = 0;
      end else if (e_req) begin
        lock_v = 1; lock_d = sel_d;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    use_rr = 0;
    rstn = 0;
    idle();
    test_reset();
    test_single_fetch();
    test_contention();
    test_round_robin();
    test_lock();
    test_full();
    test_flush();
    test_flush_same_cycle();
    test_reset_mid();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (port I) and the load/store requester (port D).
- Uses a req/gnt/rvalid protocol with pipelined, in-order responses.
- Tracks outstanding transactions in an owner-ID FIFO so each response returns to the requester that issued it.
- Supports discarding instruction responses still in flight when the fetch stage is flushed on a PC change.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; power of two, range 1..8.
- D_PRIORITY, 1, 1 = port D has fixed priority over port I; 0 = round-robin.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_req_i  in  1  fetch request
- i_addr_i  in  32  fetch address
- i_gnt_o  out  1  fetch request accepted
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  32  fetch response data
- i_err_o  out  1  fetch response error
- i_flush_i  in  1  discard all fetch responses outstanding at this edge
- d_req_i  in  1  data request
- d_we_i  in  1  data write enable
- d_be_i  in  4  data byte enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  data write data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  32  data response data
- d_err_o  out  1  data response error
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable (0 for fetch)
- mem_be_o  out  4  memory byte enables (4'hF for fetch)
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data (0 for fetch)
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- mem_err_i  in  1  memory response error
- busy_o  out  1  outstanding count is nonzero
- proto_err_o  out  1  sticky: mem_rvalid_i arrived with no outstanding entry

Behaviour:
- Reset (rstn=0 at posedge clk) clears the following, even mid-transaction:
  - count, FIFO pointers and entries, discard bits
  - lock register, round-robin pointer (last-granted = D), proto_err_o
- After reset with idle inputs, every output is 0.
- Responses from memory to transactions issued before reset are not forwarded; if the count is 0 they set proto_err_o.
- Selection (combinational), evaluated in this order:
  - If the lock is valid, select the locked owner.
  - Else if only one requester asserts req, select it.
  - Else if both assert req, D_PRIORITY=1 selects D; D_PRIORITY=0 selects the port not granted last.
- full = (count == MAX_OUTSTANDING).
  - mem_req_o = selected req & !full.
  - mem_* payload is muxed from the selected port.
- Grant: sel_gnt = mem_req_o & mem_gnt_i, combinational, zero added latency.
  - Forwarded only on the selected port's gnt_o; the other gnt_o is 0.
- Lock:
  - Set to the owner when mem_req_o=1 and mem_gnt_i=0.
  - Cleared on that owner's grant.
  - While locked, the other requester is never granted, so the memory request stays stable until gnt.
- Full: while full, mem_req_o=0 and no gnt is issued, even if mem_rvalid_i pops in the same cycle. The grant is issued next cycle at the earliest.
- FIFO push on sel_gnt stores {owner, discard=0}.
- FIFO pop on mem_rvalid_i with count>0:
  - The head entry's owner receives rvalid/rdata/err the same cycle, combinationally from mem_*.
  - If the head's discard bit is set, nothing is forwarded.
  - Non-owner rdata outputs are 0.
- Push and pop in the same cycle leave count unchanged; the pointers wrap modulo MAX_OUTSTANDING.
- i_flush_i at an edge sets discard on every valid I-owned entry, including a head popping that same cycle; that pop is suppressed combinationally.
  - An I request granted in the flush cycle is not discarded; the fetch stage presents the new PC in that cycle.
  - D entries are unaffected.
- mem_rvalid_i with count==0 sets proto_err_o (held until reset) and is otherwise ignored.
- busy_o = (count != 0), registered state.

Test Plan:
- Single fetch: i_req_i=1, addr=0x100, mem_gnt_i=1 same cycle; mem_rvalid_i next cycle with rdata=0x00000013 -> i_gnt_o=1 in cycle 0, i_rvalid_o=1 with i_rdata_o=0x00000013 in cycle 1, d_rvalid_o=0, busy_o 1 then 0.
- Contention, D_PRIORITY=1: both ports request, mem_gnt_i=1 for 3 cycles, d_req_i held 2 cycles -> D granted cycles 0-1, I granted cycle 2; responses routed D, D, I in order.
- Round-robin, D_PRIORITY=0: both ports request continuously, mem_gnt_i=1 -> grants alternate I, D, I, D (last-granted resets to D).
- Lock/stall: I selected, mem_gnt_i=0 for 3 cycles, d_req_i rises in cycle 1 -> mem_addr_o stays at I address, d_gnt_o=0 until I is granted in cycle 3, then D is granted.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid -> third request sees mem_req_o=0; rvalid in cycle k -> grant at cycle k+1.
- Flush: two I fetches outstanding, i_flush_i pulse, then two rvalids -> i_rvalid_o stays 0, busy_o falls after the second rvalid; a later fetch returns normally; a stray rvalid with count 0 sets proto_err_o=1.
